// File: rtl/lc3_datapath_gen.sv
// LC-3 shared-bus datapath generalised in data/address width, with a variable-latency
// memory handshake FSM, timeout error path and bus-contention monitor. Optional macro: PERF_CNT_EN.
module lc3_datapath_gen #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned RESET_PC    = 'h3000,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset_al,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              LD_IR,
    input  logic              LD_BEN,
    input  logic              LD_CC,
    input  logic              LD_REG,
    input  logic              LD_PC,
    input  logic              GatePC,
    input  logic              GateMDR,
    input  logic              GateALU,
    input  logic              GateMARMUX,
    input  logic [1:0]        PCMUX,
    input  logic              DRMUX,
    input  logic              SR1MUX,
    input  logic              SR2MUX,
    input  logic              ADDR1MUX,
    input  logic [1:0]        ADDR2MUX,
    input  logic [1:0]        ALUK,
    input  logic              Mem_start,
    input  logic              Mem_we,
    output logic              Mem_req,
    output logic              Mem_wr,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [DATA_W-1:0] Mem_wdata,
    input  logic [DATA_W-1:0] Mem_rdata,
    input  logic              Mem_ack,
    output logic              Mem_done,
    output logic              Mem_err,
`ifdef PERF_CNT_EN
    output logic [31:0]       Perf_mem_cnt,
    output logic [31:0]       Perf_stall_cnt,
`endif
    output logic [15:0]       IR,
    output logic              BEN,
    output logic [ADDR_W-1:0] PC,
    output logic              Bus_conflict
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
    localparam logic [7:0]        TMO_INIT = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } mem_state_t;

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_regs [8];
    logic [2:0]        r_nzp;
    logic              r_ben;
    logic              r_we;
    logic [7:0]        r_tmo;
    logic              r_err;
    logic              r_conflict;

    logic [2:0]        w_dr;
    logic [2:0]        w_sr1;
    logic [DATA_W-1:0] w_sr1_val;
    logic [DATA_W-1:0] w_sr2_val;
    logic [DATA_W-1:0] w_imm5;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_alu;
    logic [ADDR_W-1:0] w_off6;
    logic [ADDR_W-1:0] w_off9;
    logic [ADDR_W-1:0] w_off11;
    logic [ADDR_W-1:0] w_addr1;
    logic [ADDR_W-1:0] w_addr2;
    logic [ADDR_W-1:0] w_adder;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [DATA_W-1:0] w_bus;
    logic [2:0]        w_nzp;
    logic              w_multi_gate;
    logic              w_busy;
    logic              w_rd_ack;
    logic              w_expire;

    // Register file addressing and operand selection
    assign w_dr      = DRMUX  ? 3'd7       : r_ir[11:9];
    assign w_sr1     = SR1MUX ? r_ir[8:6]  : r_ir[11:9];
    assign w_sr1_val = r_regs[w_sr1];
    assign w_sr2_val = r_regs[r_ir[2:0]];

    assign w_imm5  = {{(DATA_W-5){r_ir[4]}}, r_ir[4:0]};
    assign w_off6  = {{(ADDR_W-6){r_ir[5]}}, r_ir[5:0]};
    assign w_off9  = {{(ADDR_W-9){r_ir[8]}}, r_ir[8:0]};
    assign w_off11 = {{(ADDR_W-11){r_ir[10]}}, r_ir[10:0]};

    assign w_alu_b = SR2MUX ? w_imm5 : w_sr2_val;

    always_comb begin
        case (ALUK)
            2'd0:    w_alu = w_sr1_val + w_alu_b;
            2'd1:    w_alu = w_sr1_val & w_alu_b;
            2'd2:    w_alu = ~w_sr1_val;
            default: w_alu = w_sr1_val;
        endcase
    end

    assign w_addr1 = ADDR1MUX ? w_sr1_val[ADDR_W-1:0] : r_pc;

    always_comb begin
        case (ADDR2MUX)
            2'd0:    w_addr2 = '0;
            2'd1:    w_addr2 = w_off6;
            2'd2:    w_addr2 = w_off9;
            default: w_addr2 = w_off11;
        endcase
    end

    assign w_adder = w_addr1 + w_addr2;

    // Wired-OR bus; address-width sources are zero-extended
    always_comb begin
        w_bus = '0;
        if (GatePC)     w_bus = w_bus | DATA_W'(r_pc);
        if (GateMDR)    w_bus = w_bus | r_mdr;
        if (GateALU)    w_bus = w_bus | w_alu;
        if (GateMARMUX) w_bus = w_bus | DATA_W'(w_adder);
    end

    assign w_multi_gate = (GatePC  & (GateMDR | GateALU | GateMARMUX)) |
                          (GateMDR & (GateALU | GateMARMUX)) |
                          (GateALU & GateMARMUX);

    always_comb begin
        case (PCMUX)
            2'd0:    w_pc_nxt = r_pc + ADDR_W'(1);
            2'd1:    w_pc_nxt = w_bus[ADDR_W-1:0];
            2'd2:    w_pc_nxt = w_adder;
            default: w_pc_nxt = r_pc;
        endcase
    end

    always_comb begin
        if (w_bus[DATA_W-1])  w_nzp = 3'b100;
        else if (w_bus == '0) w_nzp = 3'b010;
        else                  w_nzp = 3'b001;
    end

    assign w_busy   = (r_state == S_BUSY);
    assign w_rd_ack = w_busy & Mem_ack & ~r_we;
    assign w_expire = w_busy & ~Mem_ack & (r_tmo == 8'd1);

    // Memory FSM: state register
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Memory FSM: next state (ack takes priority over expiry)
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (Mem_start) w_state_nxt = S_BUSY;
            S_BUSY:  if (Mem_ack || r_tmo == 8'd1) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory FSM: outputs decoded from state so reset drops them asynchronously
    always_comb begin
        Mem_req  = 1'b0;
        Mem_wr   = 1'b0;
        Mem_done = 1'b0;
        case (r_state)
            S_BUSY: begin
                Mem_req = 1'b1;
                Mem_wr  = r_we;
            end
            S_DONE:  Mem_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            r_we  <= 1'b0;
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && Mem_start) begin
                r_we  <= Mem_we;
                r_tmo <= TMO_INIT;
            end else if (w_busy && !Mem_ack) begin
                r_tmo <= r_tmo - 8'd1;
            end
            if (w_expire) r_err <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            r_pc       <= PC_INIT;
            r_mar      <= '0;
            r_mdr      <= '0;
            r_ir       <= '0;
            r_nzp      <= 3'b010;
            r_ben      <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            if (LD_PC) r_pc <= w_pc_nxt;
            if (LD_MAR && !w_busy) r_mar <= w_bus[ADDR_W-1:0];
            if (w_rd_ack) r_mdr <= Mem_rdata;
            else if (LD_MDR && r_state == S_IDLE) r_mdr <= w_bus;
            if (LD_IR) r_ir <= w_bus[15:0];
            if (LD_CC) r_nzp <= w_nzp;
            if (LD_BEN) r_ben <= (r_ir[11] & r_nzp[2]) | (r_ir[10] & r_nzp[1]) | (r_ir[9] & r_nzp[0]);
            if (w_multi_gate) r_conflict <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
        end else if (LD_REG) begin
            r_regs[w_dr] <= w_bus;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] r_perf_mem;
    logic [31:0] r_perf_stall;

    // Saturating counters: successful transactions and BUSY cycles
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            r_perf_mem   <= '0;
            r_perf_stall <= '0;
        end else if (w_busy) begin
            if (r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
            if (Mem_ack && r_perf_mem != '1) r_perf_mem <= r_perf_mem + 32'd1;
        end
    end

    assign Perf_mem_cnt   = r_perf_mem;
    assign Perf_stall_cnt = r_perf_stall;
`endif

    assign Mem_addr     = r_mar;
    assign Mem_wdata    = r_mdr;
    assign Mem_err      = r_err;
    assign IR           = r_ir;
    assign BEN          = r_ben;
    assign PC           = r_pc;
    assign Bus_conflict = r_conflict;

endmodule

// File: tb/tb_lc3_datapath_gen.sv
// Self-checking bench: a 16-bit and a 32-bit datapath driven with identical stimulus,
// checked against hand-computed values from a vector table plus directed handshake sequences.
module tb_lc3_datapath_gen;

    logic        Clk = 1'b0;
    logic        Reset_al;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic        Mem_start, Mem_we, Mem_ack;
    logic [31:0] Mem_rdata;

    logic        m16_req, m16_wr, m16_done, m16_err, m16_ben, m16_conf;
    logic [15:0] m16_addr, m16_wdata, m16_ir, m16_pc;
    logic        m32_req, m32_wr, m32_done, m32_err, m32_ben, m32_conf;
    logic [15:0] m32_addr, m32_ir, m32_pc;
    logic [31:0] m32_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    lc3_datapath_gen #(.DATA_W(16), .ADDR_W(16), .RESET_PC('h3000), .MEM_TIMEOUT(15)) u_dut16 (
        .Clk(Clk), .Reset_al(Reset_al),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_start(Mem_start), .Mem_we(Mem_we), .Mem_req(m16_req), .Mem_wr(m16_wr),
        .Mem_addr(m16_addr), .Mem_wdata(m16_wdata), .Mem_rdata(Mem_rdata[15:0]),
        .Mem_ack(Mem_ack), .Mem_done(m16_done), .Mem_err(m16_err),
        .IR(m16_ir), .BEN(m16_ben), .PC(m16_pc), .Bus_conflict(m16_conf)
    );

    lc3_datapath_gen #(.DATA_W(32), .ADDR_W(16), .RESET_PC('h3000), .MEM_TIMEOUT(15)) u_dut32 (
        .Clk(Clk), .Reset_al(Reset_al),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_start(Mem_start), .Mem_we(Mem_we), .Mem_req(m32_req), .Mem_wr(m32_wr),
        .Mem_addr(m32_addr), .Mem_wdata(m32_wdata), .Mem_rdata(Mem_rdata),
        .Mem_ack(Mem_ack), .Mem_done(m32_done), .Mem_err(m32_err),
        .IR(m32_ir), .BEN(m32_ben), .PC(m32_pc), .Bus_conflict(m32_conf)
    );

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [1:0]  aluk;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] exp16;
        logic [2:0]  nzp16;
        logic [31:0] exp32;
        logic [2:0]  nzp32;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk2(input string name, input logic [31:0] a16, input logic [31:0] e16,
                        input logic [31:0] a32, input logic [31:0] e32);
        chk({name, "/w16"}, a16, e16);
        chk({name, "/w32"}, a32, e32);
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic clr();
        LD_MAR = 0; LD_MDR = 0; LD_IR = 0; LD_BEN = 0; LD_CC = 0; LD_REG = 0; LD_PC = 0;
        GatePC = 0; GateMDR = 0; GateALU = 0; GateMARMUX = 0;
        PCMUX = 0; ADDR2MUX = 0; ALUK = 0;
        DRMUX = 0; SR1MUX = 0; SR2MUX = 0; ADDR1MUX = 0;
        Mem_start = 0; Mem_we = 0; Mem_ack = 0;
    endtask

    // Read with ack on the first BUSY cycle; returns in IDLE
    task automatic mem_read(input logic [31:0] v);
        Mem_start = 1; Mem_we = 0;
        step();
        Mem_start = 0; Mem_ack = 1; Mem_rdata = v;
        step();
        Mem_ack = 0;
        step();
        step();
    endtask

    task automatic load_ir(input logic [15:0] v);
        mem_read({16'h0, v});
        GateMDR = 1; LD_IR = 1;
        step();
        GateMDR = 0; LD_IR = 0;
    endtask

    task automatic set_reg(input logic [2:0] idx, input logic [31:0] v);
        load_ir({4'h0, idx, 9'h0});
        mem_read(v);
        GateMDR = 1; LD_REG = 1; DRMUX = 0;
        step();
        GateMDR = 0; LD_REG = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t reached without finishing, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [2:0] m;

        vecs[0] = '{"add_m1_zero",   16'h107F, 2'd0, 32'h0000_0000, 32'h0, 16'hFFFF, 3'b100, 32'hFFFF_FFFF, 3'b100};
        vecs[1] = '{"add_reg_sign",  16'h1042, 2'd0, 32'h0000_7FFF, 32'h1, 16'h8000, 3'b100, 32'h0000_8000, 3'b001};
        vecs[2] = '{"add_reg_wrap",  16'h1042, 2'd0, 32'hFFFF_FFFF, 32'h1, 16'h0000, 3'b010, 32'h0000_0000, 3'b010};
        vecs[3] = '{"add_m16",       16'h1070, 2'd0, 32'h0000_0020, 32'h0, 16'h0010, 3'b001, 32'h0000_0010, 3'b001};
        vecs[4] = '{"add_m1_one",    16'h107F, 2'd0, 32'h0000_0001, 32'h0, 16'h0000, 3'b010, 32'h0000_0000, 3'b010};
        vecs[5] = '{"and_reg",       16'h5042, 2'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 16'h1200, 3'b001, 32'h00F0_1200, 3'b001};
        vecs[6] = '{"and_imm5",      16'h5065, 2'd1, 32'h8000_0007, 32'h0, 16'h0005, 3'b001, 32'h0000_0005, 3'b001};
        vecs[7] = '{"not_zero",      16'h907F, 2'd2, 32'h0000_0000, 32'h0, 16'hFFFF, 3'b100, 32'hFFFF_FFFF, 3'b100};
        vecs[8] = '{"not_hi",        16'h907F, 2'd2, 32'hFFFF_0000, 32'h0, 16'hFFFF, 3'b100, 32'h0000_FFFF, 3'b001};
        vecs[9] = '{"pass_msb",      16'h1040, 2'd3, 32'h8000_0000, 32'h0, 16'h0000, 3'b010, 32'h8000_0000, 3'b100};

        clr();
        Mem_rdata = '0;
        Reset_al  = 0;
        repeat (3) step();
        Reset_al = 1;

        chk2("rst_pc",   m16_pc, 32'h3000, m32_pc, 32'h3000);
        chk2("rst_req",  m16_req, 0, m32_req, 0);
        chk2("rst_done", m16_done, 0, m32_done, 0);
        chk2("rst_err",  m16_err, 0, m32_err, 0);
        chk2("rst_ben",  m16_ben, 0, m32_ben, 0);
        chk2("rst_ir",   m16_ir, 0, m32_ir, 0);
        chk2("rst_mar",  m16_addr, 0, m32_addr, 0);
        chk2("rst_mdr",  m16_wdata, 0, m32_wdata, 0);
        chk2("rst_conf", m16_conf, 0, m32_conf, 0);

        // NZP after reset is Z: BRz takes, BRnp does not
        load_ir(16'h0400);
        LD_BEN = 1; step(); LD_BEN = 0;
        chk2("rst_ir_brz", m16_ir, 32'h0400, m32_ir, 32'h0400);
        chk2("rst_ben_z",  m16_ben, 1, m32_ben, 1);
        load_ir(16'h0A00);
        LD_BEN = 1; step(); LD_BEN = 0;
        chk2("rst_ben_np", m16_ben, 0, m32_ben, 0);

        // Read with ack three cycles after start
        GatePC = 1; LD_MAR = 1; step(); GatePC = 0; LD_MAR = 0;
        chk2("rd_mar", m16_addr, 32'h3000, m32_addr, 32'h3000);
        Mem_start = 1; Mem_we = 0; step();
        Mem_start = 0;
        chk2("rd_req_c1", m16_req, 1, m32_req, 1);
        chk2("rd_wr_c1",  m16_wr, 0, m32_wr, 0);
        step(); step();
        chk2("rd_done_c3", m16_done, 0, m32_done, 0);
        Mem_ack = 1; Mem_rdata = 32'h0000_1234;
        step();
        Mem_ack = 0;
        chk2("rd_done_c4", m16_done, 1, m32_done, 1);
        chk2("rd_req_c4",  m16_req, 0, m32_req, 0);
        chk2("rd_mdr",     m16_wdata, 32'h1234, m32_wdata, 32'h1234);
        chk2("rd_err",     m16_err, 0, m32_err, 0);
        step();
        chk2("rd_done_c5", m16_done, 0, m32_done, 0);

        // Write; LD_MAR and LD_MDR attempts while BUSY must not take
        mem_read(32'h0000_BEEF);
        Mem_start = 1; Mem_we = 1; step();
        Mem_start = 0; Mem_we = 0;
        chk2("wr_req_c1", m16_req, 1, m32_req, 1);
        chk2("wr_wr_c1",  m16_wr, 1, m32_wr, 1);
        GateMDR = 1; LD_MAR = 1; step(); GateMDR = 0; LD_MAR = 0;
        chk2("wr_mar_hold", m16_addr, 32'h3000, m32_addr, 32'h3000);
        GatePC = 1; LD_MDR = 1; step(); GatePC = 0; LD_MDR = 0;
        chk2("wr_wr_c3",    m16_wr, 1, m32_wr, 1);
        chk2("wr_mdr_hold", m16_wdata, 32'hBEEF, m32_wdata, 32'hBEEF);
        Mem_ack = 1; Mem_rdata = 32'h0000_1111; step();
        Mem_ack = 0;
        chk2("wr_done", m16_done, 1, m32_done, 1);
        chk2("wr_wr_c4", m16_wr, 0, m32_wr, 0);
        chk2("wr_mdr_kept", m16_wdata, 32'hBEEF, m32_wdata, 32'hBEEF);
        Mem_start = 1; step(); Mem_start = 0;
        chk2("start_in_done_ignored", m16_req, 0, m32_req, 0);
        Mem_ack = 1; Mem_rdata = 32'h0000_5555; step(); Mem_ack = 0;
        chk2("ack_idle_req",  m16_req, 0, m32_req, 0);
        chk2("ack_idle_done", m16_done, 0, m32_done, 0);
        chk2("ack_idle_mdr",  m16_wdata, 32'hBEEF, m32_wdata, 32'hBEEF);
        GateMDR = 1; LD_MAR = 1; step(); GateMDR = 0; LD_MAR = 0;
        chk2("mar_idle_load", m16_addr, 32'hBEEF, m32_addr, 32'hBEEF);

        // PC mux, wrap and address adder
        mem_read(32'h0000_FFFF);
        GateMDR = 1; LD_PC = 1; PCMUX = 2'd1; step(); clr();
        chk2("pc_bus", m16_pc, 32'hFFFF, m32_pc, 32'hFFFF);
        LD_PC = 1; PCMUX = 2'd0; step(); clr();
        chk2("pc_inc_wrap", m16_pc, 32'h0000, m32_pc, 32'h0000);
        LD_PC = 1; PCMUX = 2'd3; step(); clr();
        chk2("pc_hold", m16_pc, 32'h0000, m32_pc, 32'h0000);
        load_ir(16'h0FFF);
        LD_PC = 1; PCMUX = 2'd2; ADDR1MUX = 0; ADDR2MUX = 2'd2; step(); clr();
        chk2("pc_off9_wrap", m16_pc, 32'hFFFF, m32_pc, 32'hFFFF);
        LD_PC = 1; PCMUX = 2'd2; ADDR1MUX = 0; ADDR2MUX = 2'd3; step(); clr();
        chk2("pc_off11", m16_pc, 32'hFFFE, m32_pc, 32'hFFFE);
        GateMARMUX = 1; LD_MDR = 1; ADDR1MUX = 0; ADDR2MUX = 2'd1; step(); clr();
        chk2("marmux_zext", m16_wdata, 32'hFFFD, m32_wdata, 32'h0000_FFFD);

        // Timeout with no ack; LD_MDR while BUSY is ignored
        Mem_start = 1; Mem_we = 0; step();
        Mem_start = 0;
        cyc = 1;
        while (m16_done !== 1'b1 && cyc < 40) begin
            GatePC = (cyc == 5); LD_MDR = (cyc == 5);
            step();
            cyc++;
        end
        GatePC = 0; LD_MDR = 0;
        chk("tmo_latency", cyc, 16);
        chk("tmo_done/w32", m32_done, 1);
        chk2("tmo_err",  m16_err, 1, m32_err, 1);
        chk2("tmo_req",  m16_req, 0, m32_req, 0);
        chk2("tmo_mdr",  m16_wdata, 32'hFFFD, m32_wdata, 32'h0000_FFFD);
        step(); step();
        chk2("tmo_done_low", m16_done, 0, m32_done, 0);
        chk2("tmo_err_sticky", m16_err, 1, m32_err, 1);

        // Asynchronous reset mid-transaction
        Mem_start = 1; step(); Mem_start = 0;
        chk2("mid_req", m16_req, 1, m32_req, 1);
        #2 Reset_al = 0;
        #1;
        chk2("async_rst_req", m16_req, 0, m32_req, 0);
        step();
        Reset_al = 1;
        step();
        chk2("rst2_err", m16_err, 0, m32_err, 0);
        chk2("rst2_pc",  m16_pc, 32'h3000, m32_pc, 32'h3000);

        // Ack in the same cycle the counter expires: ack wins
        Mem_start = 1; Mem_we = 0; step();
        Mem_start = 0;
        for (int k = 1; k < 15; k++) step();
        Mem_ack = 1; Mem_rdata = 32'h0000_ABCD; step();
        Mem_ack = 0;
        chk2("race_done", m16_done, 1, m32_done, 1);
        chk2("race_err",  m16_err, 0, m32_err, 0);
        chk2("race_mdr",  m16_wdata, 32'hABCD, m32_wdata, 32'hABCD);
        step();

        // DRMUX selects R7; base-register address path
        load_ir(16'h0000);
        mem_read(32'h00C0_FFEE);
        GateMDR = 1; LD_REG = 1; DRMUX = 1; step(); clr();
        ALUK = 2'd3; SR1MUX = 0; GateALU = 1; LD_MDR = 1; step(); clr();
        chk2("r0_untouched", m16_wdata, 0, m32_wdata, 0);
        load_ir(16'h0E00);
        ALUK = 2'd3; SR1MUX = 0; GateALU = 1; LD_MDR = 1; step(); clr();
        chk2("r7_write", m16_wdata, 32'hFFEE, m32_wdata, 32'h00C0_FFEE);
        LD_PC = 1; PCMUX = 2'd2; ADDR1MUX = 1; SR1MUX = 0; ADDR2MUX = 2'd0; step(); clr();
        chk2("pc_baser", m16_pc, 32'hFFEE, m32_pc, 32'hFFEE);

        // Bus contention is sticky
        chk2("conf_pre", m16_conf, 0, m32_conf, 0);
        GatePC = 1; GateALU = 1; step(); clr();
        chk2("conf_set", m16_conf, 1, m32_conf, 1);
        repeat (3) step();
        chk2("conf_sticky", m16_conf, 1, m32_conf, 1);

        // ALU / NZP / BEN vector table
        for (int i = 0; i < NV; i++) begin
            set_reg(3'd1, vecs[i].a);
            set_reg(3'd2, vecs[i].b);
            load_ir(vecs[i].ir);
            SR1MUX = 1; SR2MUX = vecs[i].ir[5]; ALUK = vecs[i].aluk; DRMUX = 0;
            GateALU = 1; LD_MDR = 1; LD_CC = 1; LD_REG = 1;
            step(); clr();
            chk2({vecs[i].name, "_bus"}, m16_wdata, {16'h0, vecs[i].exp16}, m32_wdata, vecs[i].exp32);
            load_ir(16'h0000);
            ALUK = 2'd3; SR1MUX = 0; GateALU = 1; LD_MDR = 1; step(); clr();
            chk2({vecs[i].name, "_r0"}, m16_wdata, {16'h0, vecs[i].exp16}, m32_wdata, vecs[i].exp32);
            for (int j = 0; j < 3; j++) begin
                m = 3'b100 >> j;
                load_ir({4'h0, m, 9'h0});
                LD_BEN = 1; step(); LD_BEN = 0;
                chk2($sformatf("%s_ben%0d", vecs[i].name, j), m16_ben, |(m & vecs[i].nzp16),
                     m32_ben, |(m & vecs[i].nzp32));
            end
        end

        Reset_al = 0; step(); Reset_al = 1; step();
        chk2("conf_reset", m16_conf, 0, m32_conf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
